beeper_seq: RTL and testbench
=============================

# beeper_seq

Parametrised multi-channel tone/burst generator that drives piezo beepers from a single system clock. Each channel produces a square-wave tone of programmable half-period, gated into a programmable on/off burst pattern with a repeat count or continuous mode, and supports start and stop commands. The block sits between the control logic, which issues per-channel start/stop pulses with configuration, and the board beeper pins, driven per-channel or through the OR-mixed output.

## Interface
- CH, 2, number of independent channels
- DIV_W, 16, width of tone half-period in clk cycles
- DUR_W, 12, width of on/off durations in ticks
- REP_W, 4, width of repeat count
- TICK_DIV, 1000, clk cycles per duration tick (≥1)
- clk  in  1  single system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  CH  per-channel start pulse
- stop  in  CH  per-channel abort pulse
- half_per  in  CH*DIV_W  tone half-period, channel i at [i*DIV_W +: DIV_W]
- on_len  in  CH*DUR_W  tone-on duration in ticks
- off_len  in  CH*DUR_W  silence duration between beeps, in ticks
- repeat  in  CH*REP_W  beeps per burst; 0 means continuous
- beep  out  CH  registered tone output per channel
- beep_mix  out  1  OR of all beep bits, combinational from registers
- busy  out  CH  channel not IDLE
- done  out  CH  one-cycle pulse on natural burst completion

## Operation
- Per-channel FSM with states IDLE, ON and OFF, plus a per-channel prescaler (0..TICK_DIV-1), tone divider, duration counter and repeat counter.
- IDLE, start=1, on_len≠0: latch half_per, on_len, off_len and repeat; enter ON; set beep=1; clear all counters. Later input changes are ignored until the next start.
- start with on_len=0: ignored.
- start while busy: ignored, with no restart.
- half_per=0: treated as 1, so the tone toggles every cycle.
- off_len=0: treated as 1.
- ON, tone: div_cnt increments each cycle. When div_cnt==hp-1, toggle beep and set div_cnt to 0. Tone period is 2*hp cycles.
- ON and OFF, duration: the prescaler wraps at TICK_DIV-1 and produces a tick. On each tick dur_cnt increments. When tick and dur_cnt==len-1, the phase ends and dur_cnt is cleared.
- End of ON:
  - rep_cnt increments.
  - If repeat≠0 and rep_cnt+1==repeat: go to IDLE, beep=0, done=1 for one cycle.
  - Otherwise: go to OFF with beep=0.
- End of OFF: go to ON with beep=1, div_cnt=0.
- Continuous mode (repeat=0): cycles ON/OFF until stop; rep_cnt saturates and does not wrap.
- stop in ON or OFF: go to IDLE next edge, beep=0, no done pulse.
- stop in IDLE: no effect.
- start and stop in the same cycle: stop wins, and the channel stays or returns to IDLE.
- Channels are fully independent, and simultaneous events on different channels do not interact.
- rst=1: all states IDLE, all counters 0, beep=0, done=0, busy=0. Reset overrides everything, including mid-burst activity.

## Timing
- Start-to-tone latency: start sampled at edge k gives beep=1 and busy=1 after edge k.
- Each ON phase lasts exactly on_len*TICK_DIV cycles, and each OFF phase lasts off_len*TICK_DIV cycles. The prescaler restarts at each start, so durations are exact.
- A burst has repeat ON phases and repeat-1 OFF phases, with no trailing OFF.
- Burst completion: busy falls at the same edge where done rises; done is high for exactly one cycle.
- Stop latency is one edge.
- beep_mix follows beep in the same cycle.
- Reset values: beep=0, beep_mix=0, busy=0, done=0.

## Test plan
- Reset and idle:
  - Stimulus: assert rst for 3 cycles with start held high.
  - Response: all outputs 0 throughout; after release, busy stays 0 until a fresh start.
- Basic burst:
  - Stimulus: TICK_DIV=4, half_per=2, on_len=2, off_len=1, repeat=2, start at edge 0.
  - Response:
    - beep=1,0,1,0 toggling at edges 0, 2, 4 and 6.
    - beep=0 from edge 8 to 12, then tone again from edge 12.
    - IDLE at edge 20, done high only for cycle 20–21.
    - busy high from edge 0 to 20.
- Continuous and stop:
  - Stimulus: repeat=0, on_len=1, off_len=1, TICK_DIV=4; run 10 bursts, then pulse stop mid-ON.
  - Response: the pattern repeats with an 8-cycle period; beep=0 and busy=0 one edge after stop; done never pulses.
- Edge configs:
  - Stimulus 1: half_per=0. Response: beep toggles every cycle.
  - Stimulus 2: on_len=0. Response: start ignored, busy stays 0.
  - Stimulus 3: off_len=0. Response: behaves exactly as off_len=1.
- Collisions:
  - Stimulus 1: start+stop in the same cycle. Response: channel remains IDLE.
  - Stimulus 2: start during busy, with config changed mid-burst. Response: ignored; the burst completes with the originally latched timing.
- Multi-channel:
  - Stimulus: CH=2 with different half_per values, both started, then ch0 stopped.
  - Response: beep_mix equals the OR of both channels; ch1 is unaffected; rst mid-burst clears both next edge.

Source files
------------

// File: rtl/beeper_seq.sv
// Multi-channel piezo tone/burst generator: per-channel square-wave tone gated into
// on/off bursts with a repeat count or continuous mode, plus a start/stop command pair.
module beeper_seq #(
    parameter int unsigned CH       = 2,
    parameter int unsigned DIV_W    = 16,
    parameter int unsigned DUR_W    = 12,
    parameter int unsigned REP_W    = 4,
    parameter int unsigned TICK_DIV = 1000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [CH-1:0]       start_i,
    input  logic [CH-1:0]       stop_i,
    input  logic [CH*DIV_W-1:0] half_per_i,
    input  logic [CH*DUR_W-1:0] on_len_i,
    input  logic [CH*DUR_W-1:0] off_len_i,
    input  logic [CH*REP_W-1:0] repeat_i,
    output logic [CH-1:0]       beep_o,
    output logic                beep_mix_o,
    output logic [CH-1:0]       busy_o,
    output logic [CH-1:0]       done_o
);

    localparam int unsigned PreW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PreW-1:0] PreMax = PreW'(TICK_DIV - 1);

    typedef enum logic [1:0] {StIdle, StOn, StOff} state_e;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        state_e           state_q;
        logic [DIV_W-1:0] hp_q, div_q;
        logic [DUR_W-1:0] on_q, off_q, dur_q;
        logic [REP_W-1:0] rep_q, rep_cnt_q;
        logic [PreW-1:0]  pre_q;
        logic             beep_q, done_q;

        logic [DIV_W-1:0] hp_in;
        logic [DUR_W-1:0] on_in, off_in, len;
        logic [REP_W-1:0] rep_in;
        logic             tick, phase_end;

        assign hp_in     = half_per_i[i*DIV_W +: DIV_W];
        assign on_in     = on_len_i[i*DUR_W +: DUR_W];
        assign off_in    = off_len_i[i*DUR_W +: DUR_W];
        assign rep_in    = repeat_i[i*REP_W +: REP_W];
        assign tick      = (pre_q == PreMax);
        assign len       = (state_q == StOn) ? on_q : off_q;
        assign phase_end = tick && (dur_q == len - DUR_W'(1));

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state_q   <= StIdle;
                hp_q      <= '0;
                div_q     <= '0;
                on_q      <= '0;
                off_q     <= '0;
                dur_q     <= '0;
                rep_q     <= '0;
                rep_cnt_q <= '0;
                pre_q     <= '0;
                beep_q    <= 1'b0;
                done_q    <= 1'b0;
            end else begin
                done_q <= 1'b0;
                case (state_q)
                    StIdle: begin
                        // stop in the same cycle as start keeps the channel idle
                        if (start_i[i] && !stop_i[i] && on_in != '0) begin
                            hp_q      <= (hp_in == '0) ? DIV_W'(1) : hp_in;
                            on_q      <= on_in;
                            off_q     <= (off_in == '0) ? DUR_W'(1) : off_in;
                            rep_q     <= rep_in;
                            div_q     <= '0;
                            dur_q     <= '0;
                            rep_cnt_q <= '0;
                            pre_q     <= '0;
                            beep_q    <= 1'b1;
                            state_q   <= StOn;
                        end
                    end
                    default: begin
                        if (stop_i[i]) begin
                            state_q <= StIdle;
                            beep_q  <= 1'b0;
                        end else begin
                            pre_q <= tick ? '0 : pre_q + PreW'(1);
                            if (tick) begin
                                dur_q <= phase_end ? '0 : dur_q + DUR_W'(1);
                            end
                            if (state_q == StOn) begin
                                if (phase_end) begin
                                    if (rep_cnt_q != '1) begin
                                        rep_cnt_q <= rep_cnt_q + REP_W'(1);
                                    end
                                    beep_q <= 1'b0;
                                    if (rep_q != '0 && rep_cnt_q + REP_W'(1) == rep_q) begin
                                        state_q <= StIdle;
                                        done_q  <= 1'b1;
                                    end else begin
                                        state_q <= StOff;
                                    end
                                end else if (div_q == hp_q - DIV_W'(1)) begin
                                    beep_q <= ~beep_q;
                                    div_q  <= '0;
                                end else begin
                                    div_q <= div_q + DIV_W'(1);
                                end
                            end else if (phase_end) begin
                                state_q <= StOn;
                                beep_q  <= 1'b1;
                                div_q   <= '0;
                            end
                        end
                    end
                endcase
            end
        end

        assign beep_o[i] = beep_q;
        assign done_o[i] = done_q;
        assign busy_o[i] = (state_q != StIdle);
    end

    assign beep_mix_o = |beep_o;

endmodule

// File: tb/tb_beeper_seq.sv
// Directed self-checking bench for beeper_seq with TICK_DIV=4 and two channels.
module tb_beeper_seq;

    localparam int unsigned CH    = 2;
    localparam int unsigned DIV_W = 16;
    localparam int unsigned DUR_W = 12;
    localparam int unsigned REP_W = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [CH-1:0]       start, stop;
    logic [CH*DIV_W-1:0] half_per;
    logic [CH*DUR_W-1:0] on_len, off_len;
    logic [CH*REP_W-1:0] rep;
    logic [CH-1:0]       beep, busy, done;
    logic                beep_mix;

    int total = 0;
    int bad   = 0;

    beeper_seq #(
        .CH(CH), .DIV_W(DIV_W), .DUR_W(DUR_W), .REP_W(REP_W), .TICK_DIV(4)
    ) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop),
        .half_per_i(half_per), .on_len_i(on_len), .off_len_i(off_len), .repeat_i(rep),
        .beep_o(beep), .beep_mix_o(beep_mix), .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int e, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s e=%0d: got %0h want %0h", tag, e, obs, exp);
        end
    endtask

    task automatic cfg(input int ch, input int hp, input int on, input int off, input int r);
        half_per[ch*DIV_W +: DIV_W] = DIV_W'(hp);
        on_len[ch*DUR_W +: DUR_W]   = DUR_W'(on);
        off_len[ch*DUR_W +: DUR_W]  = DUR_W'(off);
        rep[ch*REP_W +: REP_W]      = REP_W'(r);
    endtask

    initial begin
        logic eb, e1;
        rst = 1'b1; start = '1; stop = '0;
        half_per = '0; on_len = '0; off_len = '0; rep = '0;
        cfg(0, 2, 2, 1, 2);
        cfg(1, 2, 2, 1, 2);

        // Reset with start held high
        for (int e = 0; e < 3; e++) begin
            tick();
            chk("rst_beep", e, 32'(beep), 32'd0);
            chk("rst_busy", e, 32'(busy), 32'd0);
            chk("rst_done", e, 32'(done), 32'd0);
            chk("rst_mix", e, 32'(beep_mix), 32'd0);
        end
        rst = 1'b0; start = '0;
        for (int e = 0; e < 2; e++) begin
            tick();
            chk("idle_busy", e, 32'(busy), 32'd0);
        end

        // Basic burst on ch0; restart attempt with new config at edge 5 must be ignored
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        for (int e = 0; e < 22; e++) begin
            eb = (e < 8 && (e / 2) % 2 == 0) || (e >= 12 && e < 20 && ((e - 12) / 2) % 2 == 0);
            chk("burst_beep", e, 32'(beep[0]), 32'(eb));
            chk("burst_busy", e, 32'(busy[0]), 32'(e < 20));
            chk("burst_done", e, 32'(done[0]), 32'(e == 20));
            chk("burst_ch1", e, 32'(busy[1]), 32'd0);
            if (e == 5) begin
                cfg(0, 7, 9, 5, 1);
                start[0] = 1'b1;
            end else begin
                start[0] = 1'b0;
            end
            tick();
        end

        // Continuous mode with half_per=0: period 8, stop mid-ON
        cfg(0, 0, 1, 1, 0);
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        for (int e = 0; e < 82; e++) begin
            chk("cont_beep", e, 32'(beep[0]), 32'((e % 8) < 4 && (e % 2) == 0));
            chk("cont_busy", e, 32'(busy[0]), 32'd1);
            chk("cont_done", e, 32'(done[0]), 32'd0);
            if (e == 81) stop[0] = 1'b1;
            tick();
        end
        stop[0] = 1'b0;
        chk("stop_beep", 82, 32'(beep[0]), 32'd0);
        chk("stop_busy", 82, 32'(busy[0]), 32'd0);
        chk("stop_done", 82, 32'(done[0]), 32'd0);
        tick();
        chk("stop_done2", 83, 32'(done[0]), 32'd0);

        // on_len=0 start is ignored
        cfg(0, 2, 0, 1, 1);
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        chk("on0_busy", 0, 32'(busy[0]), 32'd0);
        tick();
        chk("on0_beep", 1, 32'(beep[0]), 32'd0);

        // off_len=0 behaves as off_len=1
        cfg(0, 4, 1, 0, 2);
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        for (int e = 0; e < 14; e++) begin
            chk("off0_beep", e, 32'(beep[0]), 32'(e < 4 || (e >= 8 && e < 12)));
            chk("off0_busy", e, 32'(busy[0]), 32'(e < 12));
            chk("off0_done", e, 32'(done[0]), 32'(e == 12));
            tick();
        end

        // start and stop together: stop wins
        cfg(0, 2, 2, 1, 1);
        start[0] = 1'b1; stop[0] = 1'b1;
        tick();
        start[0] = 1'b0; stop[0] = 1'b0;
        chk("coll_busy", 0, 32'(busy[0]), 32'd0);
        chk("coll_beep", 0, 32'(beep[0]), 32'd0);

        // Two channels, different tones; stop ch0; then reset mid-burst
        cfg(0, 1, 4, 1, 0);
        cfg(1, 3, 4, 1, 0);
        start = 2'b11;
        tick();
        start = 2'b00;
        for (int e = 0; e < 14; e++) begin
            eb = (e < 10) && (e % 2 == 0);
            e1 = ((e / 3) % 2 == 0);
            chk("mc_beep0", e, 32'(beep[0]), 32'(eb));
            chk("mc_beep1", e, 32'(beep[1]), 32'(e1));
            chk("mc_mix", e, 32'(beep_mix), 32'(eb | e1));
            chk("mc_busy", e, 32'(busy), (e < 10) ? 32'd3 : 32'd2);
            stop[0] = (e == 9);
            if (e == 13) rst = 1'b1;
            tick();
        end
        rst = 1'b0;
        chk("mc_rst_beep", 14, 32'(beep), 32'd0);
        chk("mc_rst_busy", 14, 32'(busy), 32'd0);
        chk("mc_rst_mix", 14, 32'(beep_mix), 32'd0);
        chk("mc_rst_done", 14, 32'(done), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
